sram_dual_port_arbiter: RTL and testbench

Shares the two ports of the 1024x8 dual-port SRAM macro among NREQ independent requesters (stimulation sequencer, SPI host, readout engine, ...). Each cycle it grants up to two requests in round-robin order, one to each SRAM port. It blocks same-address hazards within a cycle and returns read data, or a write acknowledge, to the originating requester through a fixed-latency response pipeline. It sits directly between the requester fabric and the SRAM's CEB/CMD/ADD/DIN/Q pins.

---
 rtl/sram_dual_port_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_sram_dual_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dual_port_arbiter.sv
// sram_dual_port_arbiter
//
// Shares both ports of a dual-port SRAM macro among NREQ requesters. Each cycle
// up to two requests are granted in round-robin order. The first valid requester
// at or after the pointer goes to port 1, and the next one goes to port 2.
// A same-address pair is split when either side writes. Responses return through
// a fixed two-stage pipeline: accept at edge E, RSP_VALID after edge E+2.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   HOLD                     suppress new grants; in-flight operations complete
//   REQ_VALID/WE/ADDR/WDATA  packed per-requester request fields
//   REQ_READY                combinational grant per requester
//   RSP_VALID/RSP_DATA       one-cycle response pulse and held response data
//   CEBn/CMDn/ADDn/DINn      SRAM port n controls (CEB active low, CMD 0 = write)
//   Q1, Q2                   SRAM read data (registered inside the macro)

module sram_dual_port_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 10,
    parameter int unsigned DW   = 8,
    parameter int unsigned IW   = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              HOLD,
    input  logic [NREQ-1:0]   REQ_VALID,
    input  logic [NREQ-1:0]   REQ_WE,
    input  logic [NREQ*AW-1:0] REQ_ADDR,
    input  logic [NREQ*DW-1:0] REQ_WDATA,
    output logic [NREQ-1:0]   REQ_READY,
    output logic [NREQ-1:0]   RSP_VALID,
    output logic [NREQ*DW-1:0] RSP_DATA,
    output logic              CEB1,
    output logic              CEB2,
    output logic              CMD1,
    output logic              CMD2,
    output logic [AW-1:0]     ADD1,
    output logic [AW-1:0]     ADD2,
    output logic [DW-1:0]     DIN1,
    output logic [DW-1:0]     DIN2,
    input  logic [DW-1:0]     Q1,
    input  logic [DW-1:0]     Q2
);

    // (base + off) mod NREQ, assuming base < NREQ
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base,
                                               input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        return IW'(s % NREQ);
    endfunction

    logic [IW-1:0] ptr_q, ptr_d;

    // Arbitration
    logic          a_found, b_found;
    logic [IW-1:0] a_idx, b_idx;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wd_a, wd_b;
    logic          we_a, we_b;
    logic          hazard, grant_ok, grant_a, grant_b;

    always_comb begin
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        // For each scan offset exactly one requester index matches, so this
        // walks requesters in order PTR, PTR+1, ... modulo NREQ.
        for (int unsigned k = 0; k < NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (REQ_VALID[i] && wrap_idx(ptr_q, k) == IW'(i)) begin
                    if (!a_found) begin
                        a_found = 1'b1;
                        a_idx   = IW'(i);
                    end else if (!b_found) begin
                        b_found = 1'b1;
                        b_idx   = IW'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        addr_a = '0;
        addr_b = '0;
        wd_a   = '0;
        wd_b   = '0;
        we_a   = 1'b0;
        we_b   = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (a_idx == IW'(i)) begin
                addr_a = REQ_ADDR[i*AW +: AW];
                wd_a   = REQ_WDATA[i*DW +: DW];
                we_a   = REQ_WE[i];
            end
            if (b_idx == IW'(i)) begin
                addr_b = REQ_ADDR[i*AW +: AW];
                wd_b   = REQ_WDATA[i*DW +: DW];
                we_b   = REQ_WE[i];
            end
        end
    end

    assign hazard   = (addr_a == addr_b) && (we_a || we_b);
    assign grant_ok = !HOLD && !RST;
    assign grant_a  = grant_ok && a_found;
    assign grant_b  = grant_ok && b_found && !hazard;

    always_comb begin
        REQ_READY = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if ((grant_a && a_idx == IW'(i)) || (grant_b && b_idx == IW'(i))) begin
                REQ_READY[i] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_b) begin
            ptr_d = wrap_idx(b_idx, 1);
        end else if (grant_a) begin
            ptr_d = wrap_idx(a_idx, 1);
        end
    end

    // Stage 1 drives the SRAM pins directly; element 0 is port 1, element 1 is port 2.
    logic [1:0]    s1_ceb_q, s1_cmd_q;
    logic [IW-1:0] s1_tag_q [2];
    logic [AW-1:0] s1_add_q [2];
    logic [DW-1:0] s1_din_q [2];

    // Stage 2: operation executed by the SRAM, waiting for Q.
    logic [1:0]    s2_v_q, s2_we_q;
    logic [IW-1:0] s2_tag_q [2];
    logic [DW-1:0] s2_wd_q  [2];

    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [NREQ*DW-1:0] rsp_data_q, rsp_data_d;
    logic [DW-1:0]      q_in [2];

    assign q_in[0] = Q1;
    assign q_in[1] = Q2;

    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (s2_v_q[p] && s2_tag_q[p] == IW'(i)) begin
                    rsp_valid_d[i]          = 1'b1;
                    rsp_data_d[i*DW +: DW] = s2_we_q[p] ? s2_wd_q[p] : q_in[p];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q       <= '0;
            s1_ceb_q    <= 2'b11;
            s1_cmd_q    <= 2'b11;
            s1_tag_q[0] <= '0;
            s1_tag_q[1] <= '0;
            s1_add_q[0] <= '0;
            s1_add_q[1] <= '0;
            s1_din_q[0] <= '0;
            s1_din_q[1] <= '0;
            s2_v_q      <= '0;
            s2_we_q     <= '0;
            s2_tag_q[0] <= '0;
            s2_tag_q[1] <= '0;
            s2_wd_q[0]  <= '0;
            s2_wd_q[1]  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q <= ptr_d;

            s1_ceb_q[0] <= !grant_a;
            s1_cmd_q[0] <= !(grant_a && we_a);
            if (grant_a) begin
                s1_tag_q[0] <= a_idx;
                s1_add_q[0] <= addr_a;
                s1_din_q[0] <= wd_a;
            end
            s1_ceb_q[1] <= !grant_b;
            s1_cmd_q[1] <= !(grant_b && we_b);
            if (grant_b) begin
                s1_tag_q[1] <= b_idx;
                s1_add_q[1] <= addr_b;
                s1_din_q[1] <= wd_b;
            end

            s2_v_q      <= ~s1_ceb_q;
            s2_we_q     <= ~s1_ceb_q & ~s1_cmd_q;
            s2_tag_q[0] <= s1_tag_q[0];
            s2_tag_q[1] <= s1_tag_q[1];
            s2_wd_q[0]  <= s1_din_q[0];
            s2_wd_q[1]  <= s1_din_q[1];

            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign CEB1      = s1_ceb_q[0];
    assign CEB2      = s1_ceb_q[1];
    assign CMD1      = s1_cmd_q[0];
    assign CMD2      = s1_cmd_q[1];
    assign ADD1      = s1_add_q[0];
    assign ADD2      = s1_add_q[1];
    assign DIN1      = s1_din_q[0];
    assign DIN2      = s1_din_q[1];
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;

endmodule

// File: tb/tb_sram_dual_port_arbiter.sv
// Directed bench for sram_dual_port_arbiter with a behavioural 1024x8 dual-port
// SRAM (content initialised to 8'hFA, Q registered on the clock edge).

module tb_sram_dual_port_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 10;
    localparam int unsigned DW   = 8;
    localparam int unsigned IW   = 3;

    logic              CLK;
    logic              RST;
    logic              HOLD;
    logic [NREQ-1:0]   REQ_VALID;
    logic [NREQ-1:0]   REQ_WE;
    logic [NREQ*AW-1:0] REQ_ADDR;
    logic [NREQ*DW-1:0] REQ_WDATA;
    logic [NREQ-1:0]   REQ_READY;
    logic [NREQ-1:0]   RSP_VALID;
    logic [NREQ*DW-1:0] RSP_DATA;
    logic              CEB1, CEB2, CMD1, CMD2;
    logic [AW-1:0]     ADD1, ADD2;
    logic [DW-1:0]     DIN1, DIN2;
    logic [DW-1:0]     Q1, Q2;

    int n_chk  = 0;
    int n_fail = 0;

    sram_dual_port_arbiter #(
        .NREQ(NREQ),
        .AW  (AW),
        .DW  (DW),
        .IW  (IW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .HOLD     (HOLD),
        .REQ_VALID(REQ_VALID),
        .REQ_WE   (REQ_WE),
        .REQ_ADDR (REQ_ADDR),
        .REQ_WDATA(REQ_WDATA),
        .REQ_READY(REQ_READY),
        .RSP_VALID(RSP_VALID),
        .RSP_DATA (RSP_DATA),
        .CEB1     (CEB1),
        .CEB2     (CEB2),
        .CMD1     (CMD1),
        .CMD2     (CMD2),
        .ADD1     (ADD1),
        .ADD2     (ADD2),
        .DIN1     (DIN1),
        .DIN2     (DIN2),
        .Q1       (Q1),
        .Q2       (Q2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SRAM model
    logic [DW-1:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= 8'hFA;
        Q1 <= '0;
        Q2 <= '0;
    end
    always @(posedge CLK) begin
        if (!CEB1) begin
            if (!CMD1) mem[ADD1] <= DIN1;
            else       Q1 <= mem[ADD1];
        end
        if (!CEB2) begin
            if (!CMD2) mem[ADD2] <= DIN2;
            else       Q2 <= mem[ADD2];
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        REQ_VALID = '0;
        REQ_WE    = '0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        REQ_VALID[i]        = 1'b1;
        REQ_WE[i]           = we;
        REQ_ADDR[i*AW +: AW] = a;
        REQ_WDATA[i*DW +: DW] = d;
    endtask

    initial begin
        RST  = 1'b1;
        HOLD = 1'b0;
        clr();
        #2;
        // Reset state
        chk("rst_ceb", {62'd0, CEB1, CEB2}, 64'h3);
        chk("rst_cmd", {62'd0, CMD1, CMD2}, 64'h3);
        chk("rst_add", {44'd0, ADD1, ADD2}, 64'h0);
        chk("rst_din", {48'd0, DIN1, DIN2}, 64'h0);
        chk("rst_rsp_valid", RSP_VALID, 64'h0);
        chk("rst_rsp_data", RSP_DATA, 64'h0);
        REQ_VALID = 4'hF;
        #1;
        chk("rst_ready", REQ_READY, 64'h0);
        clr();
        step();
        step();
        RST = 1'b0;

        // Requester 0 reads address 20 (PTR 0 -> 1)
        set_req(0, 1'b0, 10'd20, 8'h00);
        #1;
        chk("t1_ready", REQ_READY, 64'h1);
        step();
        clr();
        chk("t1_ceb1", CEB1, 64'h0);
        chk("t1_cmd1", CMD1, 64'h1);
        chk("t1_add1", ADD1, 64'd20);
        chk("t1_ceb2", CEB2, 64'h1);
        step();
        chk("t1_rsp_early", RSP_VALID, 64'h0);
        step();
        chk("t1_rsp_valid", RSP_VALID, 64'h1);
        chk("t1_rsp_data", RSP_DATA[7:0], 64'hFA);

        // Requester 1 writes 0x5A to 7, then requester 2 reads 7 (PTR 1 -> 2 -> 3)
        set_req(1, 1'b1, 10'd7, 8'h5A);
        #1;
        chk("t2_ready_w", REQ_READY, 64'h2);
        step();
        clr();
        set_req(2, 1'b0, 10'd7, 8'h00);
        #1;
        chk("t2_ready_r", REQ_READY, 64'h4);
        chk("t2_cmd1_w", CMD1, 64'h0);
        chk("t2_din1", DIN1, 64'h5A);
        step();
        clr();
        chk("t2_cmd1_r", CMD1, 64'h1);
        chk("t2_add1_r", ADD1, 64'd7);
        step();
        chk("t2_rsp_valid_w", RSP_VALID, 64'h2);
        chk("t2_rsp_data_w", RSP_DATA[15:8], 64'h5A);
        step();
        chk("t2_rsp_valid_r", RSP_VALID, 64'h4);
        chk("t2_rsp_data_r", RSP_DATA[23:16], 64'h5A);

        // All four write 0x30+i to 200+i (PTR 3: grants (3,0) then (1,2))
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 10'(200 + i), 8'(8'h30 + i));
        #1;
        chk("wr_ready1", REQ_READY, 64'h9);
        step();
        chk("wr_port1", {CEB1, CMD1, ADD1, DIN1}, {2'b00, 10'd203, 8'h33});
        chk("wr_port2", {CEB2, CMD2, ADD2, DIN2}, {2'b00, 10'd200, 8'h30});
        chk("wr_ready2", REQ_READY, 64'h6);
        step();
        clr();
        set_req(3, 1'b0, 10'd203, 8'h00);
        #1;
        chk("wr_ready3", REQ_READY, 64'h8);
        step();
        clr();
        chk("wr_rsp1", RSP_VALID, 64'h9);
        chk("wr_rsp1_data", {RSP_DATA[31:24], RSP_DATA[7:0]}, 64'h3330);
        step();
        chk("wr_rsp2", RSP_VALID, 64'h6);
        chk("wr_rsp2_data", RSP_DATA[23:8], 64'h3231);
        step();
        chk("wr_rsp3", RSP_VALID, 64'h8);
        chk("wr_rsp3_data", RSP_DATA[31:24], 64'h33);

        // All four read 200+i held 4 cycles (PTR 0): pairs (0,1),(2,3),(0,1),(2,3)
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 10'(200 + i), 8'h00);
        #1;
        chk("rd_ready1", REQ_READY, 64'h3);
        step();
        chk("rd_ports1", {CEB1, CEB2, ADD1, ADD2}, {2'b00, 10'd200, 10'd201});
        chk("rd_ready2", REQ_READY, 64'hC);
        step();
        chk("rd_ready3", REQ_READY, 64'h3);
        step();
        chk("rd_rsp1", RSP_VALID, 64'h3);
        chk("rd_ready4", REQ_READY, 64'hC);
        step();
        clr();
        chk("rd_rsp2", RSP_VALID, 64'hC);
        chk("rd_rsp2_data", RSP_DATA, 64'h33323130);
        step();
        chk("rd_rsp3", RSP_VALID, 64'h3);
        chk("rd_rsp3_data", RSP_DATA[15:0], 64'h3130);
        step();
        chk("rd_rsp4", RSP_VALID, 64'hC);
        chk("rd_rsp4_data", RSP_DATA[31:16], 64'h3332);
        step();
        chk("rd_rsp_idle", RSP_VALID, 64'h0);

        // Hazard: req0 writes 0x11 to 100, req1 reads 100 (PTR 0)
        set_req(0, 1'b1, 10'd100, 8'h11);
        set_req(1, 1'b0, 10'd100, 8'h00);
        #1;
        chk("hz_ready1", REQ_READY, 64'h1);
        step();
        chk("hz_port1", {CEB1, CMD1, ADD1, DIN1}, {2'b00, 10'd100, 8'h11});
        chk("hz_ceb2", CEB2, 64'h1);
        REQ_VALID[0] = 1'b0;
        #1;
        chk("hz_ready2", REQ_READY, 64'h2);
        step();
        clr();
        chk("hz_port1_r", {CEB1, CMD1, ADD1}, {2'b01, 10'd100});
        chk("hz_ceb2_r", CEB2, 64'h1);
        step();
        chk("hz_rsp_w", RSP_VALID, 64'h1);
        chk("hz_rsp_w_data", RSP_DATA[7:0], 64'h11);
        step();
        chk("hz_rsp_r", RSP_VALID, 64'h2);
        chk("hz_rsp_r_data", RSP_DATA[15:8], 64'h11);
        // Two reads of address 100 (PTR 2)
        set_req(2, 1'b0, 10'd100, 8'h00);
        set_req(3, 1'b0, 10'd100, 8'h00);
        #1;
        chk("rr_ready", REQ_READY, 64'hC);
        step();
        clr();
        chk("rr_ports", {CEB1, CMD1, CEB2, CMD2, ADD1, ADD2}, {4'b0101, 10'd100, 10'd100});
        step();
        step();
        chk("rr_rsp", RSP_VALID, 64'hC);
        chk("rr_rsp_data", RSP_DATA[31:16], 64'h1111);
        // Read then write to the same address (PTR 0): write is held back
        set_req(0, 1'b0, 10'd100, 8'h00);
        set_req(1, 1'b1, 10'd100, 8'h22);
        #1;
        chk("rw_ready", REQ_READY, 64'h1);
        clr();

        // HOLD: req0 reads 20 at E, HOLD for 5 edges (PTR 0 -> 1, then frozen)
        set_req(0, 1'b0, 10'd20, 8'h00);
        #1;
        chk("hd_ready0", REQ_READY, 64'h1);
        step();
        HOLD = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 10'(200 + i), 8'h00);
        #1;
        chk("hd_ready1", REQ_READY, 64'h0);
        step();
        chk("hd_ceb", {CEB1, CEB2}, 64'h3);
        chk("hd_rsp_early", RSP_VALID, 64'h0);
        step();
        chk("hd_rsp", RSP_VALID, 64'h1);
        chk("hd_rsp_data", RSP_DATA[7:0], 64'hFA);
        step();
        chk("hd_rsp_after", RSP_VALID, 64'h0);
        step();
        chk("hd_ready4", REQ_READY, 64'h0);
        step();
        chk("hd_ready5", REQ_READY, 64'h0);
        HOLD = 1'b0;
        #1;
        chk("hd_resume_ready", REQ_READY, 64'h6);
        step();
        clr();
        chk("hd_resume_ports", {CEB1, CEB2, ADD1, ADD2}, {2'b00, 10'd201, 10'd202});
        step();
        step();
        chk("hd_resume_rsp", RSP_VALID, 64'h6);
        chk("hd_resume_data", RSP_DATA[23:8], 64'h3231);

        // Reset one cycle after a read accept (PTR 3)
        set_req(0, 1'b0, 10'd200, 8'h00);
        #1;
        chk("rs_ready", REQ_READY, 64'h1);
        step();
        clr();
        chk("rs_ceb1", CEB1, 64'h0);
        step();
        RST = 1'b1;
        REQ_VALID = 4'hF;
        #1;
        chk("rs_ready_in_rst", REQ_READY, 64'h0);
        chk("rs_pins", {CEB1, CEB2, CMD1, CMD2}, 64'hF);
        chk("rs_add_din", {ADD1, ADD2, DIN1, DIN2}, 64'h0);
        chk("rs_rsp", {RSP_VALID, RSP_DATA}, 64'h0);
        clr();
        RST = 1'b0;
        step();
        chk("rs_no_rsp1", RSP_VALID, 64'h0);
        step();
        chk("rs_no_rsp2", RSP_VALID, 64'h0);
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 10'(200 + i), 8'h00);
        #1;
        chk("rs_ptr_reset", REQ_READY, 64'h3);
        clr();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
